wb_bus_arbiter_2m: RTL
======================

Name: wb_bus_arbiter_2m

Overview:
- Two-master, one-slave Wishbone arbiter for the shared memory bus.
- Master 0 is the VGA framebuffer fetch port (burst master). Master 1 is the CPU/general port.
- Master 0 has fixed priority.
- Master 1 is protected by a starvation counter.
- A bus watchdog terminates hung slave cycles with an error.
- Sits between the VGA/CPU masters and the memory controller slave.

Parameters:
STARVE_LIMIT, 64, cycles master 1 may wait while master 0 holds the bus before master 1 wins the next arbitration.
TIMEOUT, 256, cycles a granted strobe may remain un-acked before the watchdog aborts the cycle.
CNT_W, 9, width of both counters; must satisfy 2^CNT_W > max(STARVE_LIMIT, TIMEOUT).

Ports:
clk  in  1  bus clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset
mN_cyc_i / mN_stb_i / mN_we_i  in  1 each  master N (N=0,1) cycle, strobe, write enable
mN_addr_i  in  30  master N word address [31:2]
mN_cti_i  in  3  master N cycle type
mN_bte_i  in  2  master N burst type
mN_sel_i  in  4  master N byte selects
mN_data_i  in  32  master N write data
mN_data_o  out  32  read data to master N
mN_ack_o / mN_err_o  out  1 each  ack / error to master N
s_cyc_o / s_stb_o / s_we_o  out  1 each  slave cycle, strobe, write enable
s_addr_o  out  30  slave address
s_cti_o  out  3  slave cycle type
s_bte_o  out  2  slave burst type
s_sel_o  out  4  slave byte selects
s_data_o  out  32  slave write data
s_data_i  in  32  slave read data
s_ack_i  in  1  slave ack
grant_o  out  2  one-hot current grant {m1,m0}; 00 when idle

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, grant_o=00, both counters=0.
  - All s_* control outputs 0; all mN_ack_o / mN_err_o 0.
- State machine (registered): IDLE, GNT0, GNT1, ABORT.
- IDLE:
  - If m1_cyc_i and starve_cnt >= STARVE_LIMIT -> GNT1.
  - Else if m0_cyc_i -> GNT0.
  - Else if m1_cyc_i -> GNT1.
  - Grant is registered: a request asserted in cycle t drives s_cyc_o at t+1, never earlier.
- GNTx:
  - Slave outputs combinationally mux master x's cyc/stb/addr/cti/bte/sel/we/data.
  - s_ack_i is routed to mx_ack_o only. The non-granted master sees ack=0 and err=0.
  - s_data_i is broadcast to both mN_data_o.
- Release:
  - When the granted master drops cyc, return to IDLE next cycle.
  - A grant is never revoked while its cyc is high, so bursts (cti=010) are never split.
  - Minimum one IDLE cycle between consecutive grants.
- Starvation counter:
  - In GNT0 with m1_cyc_i=1: increment, saturating at 2^CNT_W-1.
  - Clear on entry to GNT1.
  - Otherwise hold.
- Watchdog:
  - In GNTx with s_stb_o=1 and s_ack_i=0: increment.
  - Clear on any s_ack_i, on stb=0, and in IDLE.
  - On reaching TIMEOUT-1 -> ABORT.
- ABORT (exactly 1 cycle):
  - s_cyc_o=s_stb_o=0; mx_err_o=1 to the last granted master.
  - Then IDLE, even if that master still holds cyc. Its request is re-arbitrated normally.
- Simultaneous events:
  - s_ack_i arriving in the same cycle the watchdog hits its limit: the ack wins, the counter clears, no abort.
  - m0 and m1 requesting together in IDLE: m0 wins unless the starvation condition holds.
- Reset mid-burst: immediate return to IDLE with all outputs low, independent of clk.
- s_cyc_o is never high in IDLE or ABORT; grant_o is always one-hot or zero.

Decomposition:
- Shared package `wb_defs`:
  - CTI constants: CTI_CLASSIC=000, CTI_CONST=001, CTI_INC=010, CTI_END=111.
  - BTE constants.
  - Arbiter state encoding localparams.
- Sub-module `wb_watchdog`:
  - Inputs: clk, rst, clr, run.
  - Output: expire.
  - Parameter: TIMEOUT.
- Starvation counter and mux stay inline.

Test Plan:
1. m0 only, 8-beat incrementing burst (cti=010 ×7 then 111), slave acks every cycle:
   - s_cyc_o rises 1 cycle after m0_cyc_i.
   - 8 m0_ack_o pulses; m1_ack_o stays 0.
   - grant_o=01, then 00 one cycle after m0_cyc_i drops.
2. m0 and m1 raise cyc in the same cycle, classic single reads:
   - m0 served first.
   - One IDLE cycle.
   - m1 granted; m1 read returns s_data_i=32'hA5A5_0001.
3. m0 holds cyc for 100 cycles with m1 requesting throughout (STARVE_LIMIT=64), then m0 drops and immediately re-requests:
   - m1 is granted, not m0.
   - starve counter reads 0 after the GNT1 entry.
4. Slave never acks m1 strobe (TIMEOUT=256):
   - m1_err_o pulses exactly at cycle 256 after stb.
   - s_cyc_o low in that cycle.
   - State returns to IDLE.
5. Slave acks at cycle TIMEOUT-1, the same cycle the watchdog would expire:
   - m1_ack_o=1, m1_err_o=0, no ABORT.
6. Assert rst=0 asynchronously mid-burst at beat 3:
   - All s_* control outputs and grant_o go 0 without a clock edge.
   - After release, the next m0 request is granted with 1-cycle latency.

Source files
------------

// File: rtl/wb_defs.sv
// Shared Wishbone definitions for the two-master memory-bus arbiter:
// cycle/burst type codes, arbiter state encoding and the bundled master request.
package wb_defs;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT0  = 2'b01,
    ST_GNT1  = 2'b10,
    ST_ABORT = 2'b11
  } arb_state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [29:0] addr;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [3:0]  sel;
    logic [31:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts consecutive un-acked strobe cycles and flags the cycle
// in which the count has reached TIMEOUT-1 while the strobe is still waiting.
module wb_watchdog #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign a default first so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // run already excludes an ack in this cycle, so a last-moment ack wins.
  assign expire = run && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_bus_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter: fixed priority for the VGA fetch
// port (m0), starvation protection for the CPU port (m1), watchdog abort.
module wb_bus_arbiter_2m
  import wb_defs::*;
#(
  parameter int unsigned STARVE_LIMIT = 64,
  parameter int unsigned TIMEOUT      = 256,
  parameter int unsigned CNT_W        = 9
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [29:0] m0_addr_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [29:0] m1_addr_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [29:0] s_addr_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,

  output logic [1:0]  grant_o
);

  arb_state_e       state_q, state_d;
  logic             owner_q, owner_d;   // last granted master, 1 = m1
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starve_hit;
  logic             wd_run, wd_expire;
  wb_req_t          m0_req, m1_req, bus_req;

  assign m0_req = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, addr: m0_addr_i,
                    cti: m0_cti_i, bte: m0_bte_i, sel: m0_sel_i, data: m0_data_i};
  assign m1_req = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, addr: m1_addr_i,
                    cti: m1_cti_i, bte: m1_bte_i, sel: m1_sel_i, data: m1_data_i};

  assign starve_hit = (starve_q >= CNT_W'(STARVE_LIMIT));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  // Next-state: grants are only taken from IDLE, so a live cycle is never split.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (m1_cyc_i && starve_hit) begin
          state_d = ST_GNT1;
          owner_d = 1'b1;
        end else if (m0_cyc_i) begin
          state_d = ST_GNT0;
          owner_d = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = ST_GNT1;
          owner_d = 1'b1;
        end
      end
      ST_GNT0: begin
        if (!m0_cyc_i)      state_d = ST_IDLE;
        else if (wd_expire) state_d = ST_ABORT;
      end
      ST_GNT1: begin
        if (!m1_cyc_i)      state_d = ST_IDLE;
        else if (wd_expire) state_d = ST_ABORT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Starvation counter: accumulates while m1 waits behind m0, cleared as m1 wins.
  always_comb begin
    starve_d = starve_q;
    if (state_q == ST_GNT0 && m1_cyc_i && starve_q != '1) begin
      starve_d = starve_q + CNT_W'(1);
    end
    if (state_d == ST_GNT1 && state_q != ST_GNT1) begin
      starve_d = '0;
    end
  end

  // Outputs: bus mux, ack routing and abort error, all decoded from the registered state.
  always_comb begin
    bus_req  = '0;
    grant_o  = 2'b00;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      ST_GNT0: begin
        bus_req  = m0_req;
        grant_o  = 2'b01;
        m0_ack_o = s_ack_i;
      end
      ST_GNT1: begin
        bus_req  = m1_req;
        grant_o  = 2'b10;
        m1_ack_o = s_ack_i;
      end
      ST_ABORT: begin
        m0_err_o = ~owner_q;
        m1_err_o = owner_q;
      end
      default: ;
    endcase
  end

  assign s_cyc_o  = bus_req.cyc;
  assign s_stb_o  = bus_req.cyc & bus_req.stb;
  assign s_we_o   = bus_req.we;
  assign s_addr_o = bus_req.addr;
  assign s_cti_o  = bus_req.cti;
  assign s_bte_o  = bus_req.bte;
  assign s_sel_o  = bus_req.sel;
  assign s_data_o = bus_req.data;

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  // s_stb_o is only ever high in a grant state, so it alone qualifies the watchdog.
  assign wd_run = s_stb_o & ~s_ack_i;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (~wd_run),
    .run    (wd_run),
    .expire (wd_expire)
  );

endmodule
